line_follow_ctrl: RTL and testbench
===================================

Name: line_follow_ctrl

Overview:
- Top-level motion controller for the line-follower robot.
- Consumes the three synchronized sensor bits produced by the input buffer (left, middle, right; 1 = line under sensor) and debounces them into a stable pattern.
- Sequences the drive state machine: follow, crossing, turn, seek, lost.
- Emits per-motor direction commands to the PWM/motor driver stage.

Parameters:
- DEBOUNCE_CYC, 4: consecutive edges a new raw pattern must be held before it is accepted.
- TURN_CYC, 20: cycles spent spinning blind after leaving a crossing.
- LOST_CYC, 50: timeout cycles with no line (FOLLOW) or no middle-sensor hit (SEEK) before entering LOST.
- CNT_W, 8: width of the internal cycle counters; must hold max(DEBOUNCE_CYC, TURN_CYC, LOST_CYC).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; IDLE/LOST -> FOLLOW.
- stop  in  1  one-cycle pulse; any state -> IDLE; has priority over start.
- sens_l, sens_m, sens_r  in  1 each  synchronized sensor bits.
- turn_sel  in  2  action at next crossing: 00 straight, 01 left, 10 right, 11 halt.
- motor_l, motor_r  out  2 each  command: 00 STOP, 01 FWD, 10 REV; 11 never driven.
- state_o  out  3  current FSM state encoding.
- crossing_cnt  out  8  crossings seen since last start; saturates at 255.
- lost  out  1  high while in LOST.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, debounced pattern pat=3'b010, dir_q=00, all counters 0.
  - crossing_cnt=0, lost=0, motors STOP, effective immediately without waiting for a clock.
- Debounce:
  - raw={sens_l,sens_m,sens_r}.
  - When raw != pat, a stability counter runs; it restarts whenever raw changes.
  - pat <= raw on the DEBOUNCE_CYC-th consecutive rising edge that samples the same raw value.
  - Any glitch shorter than that is ignored. When raw==pat, the counter holds 0.
- Outputs:
  - Decoded combinationally from registered state, pat and dir_q only; there is no input-to-output combinational path.
  - State transitions take one edge.
- IDLE (0):
  - Motors STOP/STOP.
  - start: crossing_cnt <= 0, then -> FOLLOW.
- FOLLOW (1): drive by pat:
  - 010 or 101: FWD/FWD (101 is invalid; hold straight).
  - 110, 100: STOP/FWD (steer left).
  - 011, 001: FWD/STOP (steer right).
  - 111: -> CROSS; crossing_cnt += 1 (saturating); dir_q <= turn_sel.
  - 000: lost counter increments, STOP/STOP. Any other pattern clears it. When the counter reaches LOST_CYC-1 -> LOST.
- CROSS (2):
  - FWD/FWD while pat==111.
  - On pat!=111: dir_q 00 -> FOLLOW; 01/10 -> TURN (counter cleared); 11 -> IDLE.
- TURN (3):
  - Left: REV/FWD. Right: FWD/REV.
  - pat is ignored; after TURN_CYC cycles -> SEEK.
- SEEK (4):
  - Same spin as TURN.
  - pat[1]==1 -> FOLLOW.
  - LOST_CYC cycles without a hit -> LOST.
- LOST (5):
  - STOP/STOP, lost=1.
  - start -> FOLLOW; lost clears and crossing_cnt resets.
- Simultaneous events:
  - stop and start in the same cycle: stop wins.
  - start outside IDLE/LOST is ignored.
  - turn_sel is sampled only on FOLLOW->CROSS entry; later changes do not affect an in-progress crossing.
- Counters never wrap: stop counting at the terminal value; crossing_cnt saturates at 255.
- Reset mid-turn or mid-crossing: immediate IDLE/STOP; no residual motion on release.

Decomposition:
- Package lf_pkg holds:
  - motor_cmd_t enum (STOP=2'b00, FWD=2'b01, REV=2'b10).
  - state_t enum (IDLE=0, FOLLOW=1, CROSS=2, TURN=3, SEEK=4, LOST=5).
  - turn_t enum (STRAIGHT, LEFT, RIGHT, HALT).
  - Pattern constants (PAT_CENTER=3'b010, PAT_ALL=3'b111, PAT_NONE=3'b000).
- One sub-module, sensor_debounce:
  - Parameterized by DEBOUNCE_CYC.
  - Inputs clk/reset_n/raw[2:0]; output pat[2:0].
  - Reset value 3'b010.
- FSM, counters and output decode stay in line_follow_ctrl.

Test Plan:
- Reset, then start pulse with raw=010 held -> state_o=1; motors 01/01 one edge after start; crossing_cnt=0.
- In FOLLOW, raw 010->110 held 3 edges then back to 010 -> pat never changes, motors stay 01/01; held 4 edges -> motors 00/01.
- turn_sel=01, raw=111 for 6 cycles, then raw=000 -> crossing_cnt=1, CROSS then TURN. Motors 10/01 for exactly 20 cycles, then SEEK. After raw=010 is debounced -> FOLLOW.
- raw=000 in FOLLOW for 50 cycles -> state_o=5, lost=1, motors 00/00. A start pulse -> FOLLOW and lost=0.
- turn_sel=11 at a crossing -> IDLE after the line clears. Same-cycle start+stop in FOLLOW -> IDLE.
- 256 crossings with turn_sel=00 -> crossing_cnt saturates at 255. reset_n low mid-TURN -> motors 00/00 and state_o=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/line_follow_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | lf_pkg: shared types and pattern constants for the line-follower control |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package lf_pkg;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    FWD  = 2'b01,
    REV  = 2'b10
  } motor_cmd_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    CROSS  = 3'd2,
    TURN   = 3'd3,
    SEEK   = 3'd4,
    LOST   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    STRAIGHT = 2'b00,
    LEFT     = 2'b01,
    RIGHT    = 2'b10,
    HALT     = 2'b11
  } turn_t;

  localparam logic [2:0] PAT_CENTER = 3'b010;
  localparam logic [2:0] PAT_ALL    = 3'b111;
  localparam logic [2:0] PAT_NONE   = 3'b000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_follow_ctrl_debounce.sv
// +--------------------------------------------------------------------------+
// | sensor_debounce: accepts a new 3-bit sensor pattern once it is stable    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sensor_debounce
  import lf_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] raw,
  output logic [2:0] pat
);

  localparam int DW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

  logic [2:0]    pat_q;
  logic [2:0]    last_q;
  logic [DW-1:0] run_q;
  logic [DW-1:0] run_d;

  // Run length including the current sample; a changed raw value restarts at one.
  always_comb begin
    run_d = DW'(1);
    if (raw == last_q) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= PAT_CENTER;
      last_q <= PAT_CENTER;
      run_q  <= '0;
    end else begin
      last_q <= raw;
      if (raw == pat_q) begin
        run_q <= '0;
      end else if (run_d >= DW'(DEBOUNCE_CYC)) begin
        pat_q <= raw;
        run_q <= '0;
      end else begin
        run_q <= run_d;
      end
    end
  end

  assign pat = pat_q;

endmodule

`default_nettype wire

// File: rtl/line_follow_ctrl.sv
// +--------------------------------------------------------------------------+
// | line_follow_ctrl: debounced sensor FSM driving per-motor direction cmds  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module line_follow_ctrl
  import lf_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TURN_CYC     = 20,
  parameter int LOST_CYC     = 50,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       sens_l,
  input  logic       sens_m,
  input  logic       sens_r,
  input  logic [1:0] turn_sel,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic [2:0] state_o,
  output logic [7:0] crossing_cnt,
  output logic       lost
);

  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_CYC - 1);

  logic [2:0]       pat;
  state_t           state_q;
  turn_t            dir_q;
  logic [CNT_W-1:0] tmr_q;
  logic [7:0]       xcnt_q;
  logic [7:0]       xcnt_d;
  motor_cmd_t       mot_l;
  motor_cmd_t       mot_r;

  sensor_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    ({sens_l, sens_m, sens_r}),
    .pat    (pat)
  );

  assign xcnt_d = sat_inc8(xcnt_q);

  // tmr_q is shared: no-line run in FOLLOW, spin time in TURN, search time in SEEK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dir_q   <= STRAIGHT;
      tmr_q   <= '0;
      xcnt_q  <= '0;
    end else if (stop) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            xcnt_q  <= '0;
            tmr_q   <= '0;
            state_q <= FOLLOW;
          end
        end
        FOLLOW: begin
          if (pat == PAT_ALL) begin
            xcnt_q  <= xcnt_d;
            dir_q   <= turn_t'(turn_sel);
            tmr_q   <= '0;
            state_q <= CROSS;
          end else if (pat == PAT_NONE) begin
            if (tmr_q == LOST_LAST) begin
              tmr_q   <= '0;
              state_q <= LOST;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end else begin
            tmr_q <= '0;
          end
        end
        CROSS: begin
          if (pat != PAT_ALL) begin
            tmr_q <= '0;
            case (dir_q)
              STRAIGHT: state_q <= FOLLOW;
              HALT:     state_q <= IDLE;
              default:  state_q <= TURN;
            endcase
          end
        end
        TURN: begin
          if (tmr_q == TURN_LAST) begin
            tmr_q   <= '0;
            state_q <= SEEK;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        SEEK: begin
          if (pat[1]) begin
            tmr_q   <= '0;
            state_q <= FOLLOW;
          end else if (tmr_q == LOST_LAST) begin
            tmr_q   <= '0;
            state_q <= LOST;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        LOST: begin
          if (start) begin
            xcnt_q  <= '0;
            tmr_q   <= '0;
            state_q <= FOLLOW;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mot_l = STOP;
    mot_r = STOP;
    case (state_q)
      FOLLOW: begin
        case (pat)
          3'b010, 3'b101, 3'b111: begin mot_l = FWD;  mot_r = FWD;  end
          3'b110, 3'b100:         begin mot_l = STOP; mot_r = FWD;  end
          3'b011, 3'b001:         begin mot_l = FWD;  mot_r = STOP; end
          default:                begin mot_l = STOP; mot_r = STOP; end
        endcase
      end
      CROSS: begin
        mot_l = FWD;
        mot_r = FWD;
      end
      TURN, SEEK: begin
        if (dir_q == LEFT) begin
          mot_l = REV;
          mot_r = FWD;
        end else if (dir_q == RIGHT) begin
          mot_l = FWD;
          mot_r = REV;
        end
      end
      default: begin
        mot_l = STOP;
        mot_r = STOP;
      end
    endcase
  end

  assign motor_l      = mot_l;
  assign motor_r      = mot_r;
  assign state_o      = state_q;
  assign crossing_cnt = xcnt_q;
  assign lost         = (state_q == LOST);

endmodule

`default_nettype wire

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: directed steps plus random sensor traffic against a reference model.
`default_nettype none

module tb_line_follow_ctrl;

  localparam int DEBOUNCE_CYC = 4;
  localparam int TURN_CYC     = 20;
  localparam int LOST_CYC     = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sens_l = 1'b0;
  logic       sens_m = 1'b1;
  logic       sens_r = 1'b0;
  logic [1:0] turn_sel = 2'b00;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic [2:0] state_o;
  logic [7:0] crossing_cnt;
  logic       lost;

  line_follow_ctrl #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .TURN_CYC    (TURN_CYC),
    .LOST_CYC    (LOST_CYC),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .sens_l      (sens_l),
    .sens_m      (sens_m),
    .sens_r      (sens_r),
    .turn_sel    (turn_sel),
    .motor_l     (motor_l),
    .motor_r     (motor_r),
    .state_o     (state_o),
    .crossing_cnt(crossing_cnt),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus drive values
  logic [2:0] raw_v = 3'b010;
  logic [1:0] ts_v = 2'b00;

  // Reference model: 0 idle, 1 follow, 2 crossing, 3 turn, 4 seek, 5 lost
  int         m_state;
  logic [2:0] m_pat;
  logic [1:0] m_dir;
  int         m_xcnt;
  int         none_run;
  int         turn_age;
  int         seek_age;
  logic [2:0] hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_motor(input int st, input logic [2:0] p, input logic [1:0] d);
    if (st == 1) begin
      if (p == 3'b010 || p == 3'b101 || p == 3'b111) return 4'b0101;
      if (p == 3'b110 || p == 3'b100) return 4'b0001;
      if (p == 3'b011 || p == 3'b001) return 4'b0100;
      return 4'b0000;
    end
    if (st == 2) return 4'b0101;
    if (st == 3 || st == 4) begin
      if (d == 2'b01) return 4'b1001;
      if (d == 2'b10) return 4'b0110;
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pat = 3'b010; m_dir = 2'b00; m_xcnt = 0;
    none_run = 0; turn_age = 0; seek_age = 0;
    hist.delete();
  endtask

  task automatic model_step(input logic [2:0] raw, input logic st, input logic sp, input logic [1:0] ts);
    int  ns;
    bit  same;
    ns = m_state;
    if (sp) ns = 0;
    else begin
      case (m_state)
        0: if (st) begin ns = 1; m_xcnt = 0; end
        1: begin
          if (m_pat == 3'b111) begin
            ns = 2; m_dir = ts;
            if (m_xcnt < 255) m_xcnt = m_xcnt + 1;
          end else if (m_pat == 3'b000) begin
            none_run++;
            if (none_run >= LOST_CYC) ns = 5;
          end else none_run = 0;
        end
        2: if (m_pat != 3'b111) ns = (m_dir == 2'b00) ? 1 : (m_dir == 2'b11) ? 0 : 3;
        3: begin turn_age++; if (turn_age >= TURN_CYC) ns = 4; end
        4: begin
          if (m_pat[1]) ns = 1;
          else begin seek_age++; if (seek_age >= LOST_CYC) ns = 5; end
        end
        5: if (st) begin ns = 1; m_xcnt = 0; end
        default: ns = 0;
      endcase
    end
    if (ns != m_state) begin none_run = 0; turn_age = 0; seek_age = 0; end
    m_state = ns;
    // A new pattern is taken once the last DEBOUNCE_CYC samples all agree on it
    hist.push_back(raw);
    if (hist.size() > DEBOUNCE_CYC) void'(hist.pop_front());
    if (hist.size() == DEBOUNCE_CYC && raw != m_pat) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != raw) same = 1'b0;
      if (same) m_pat = raw;
    end
  endtask

  task automatic tick(input logic st, input logic sp);
    {sens_l, sens_m, sens_r} = raw_v;
    turn_sel = ts_v;
    start = st;
    stop = sp;
    @(posedge clk);
    model_step(raw_v, st, sp, ts_v);
    #1;
    check("state", 32'(state_o), 32'(m_state));
    check("motors", 32'({motor_l, motor_r}), 32'(exp_motor(m_state, m_pat, m_dir)));
    check("crossing_cnt", 32'(crossing_cnt), 32'(m_xcnt));
    check("lost", 32'(lost), 32'(m_state == 5));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget);
    int left;
    left = budget;
    while (state_o !== target && left > 0) begin
      tick(1'b0, 1'b0);
      left--;
    end
    check("wait_state", 32'(state_o), 32'(target));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_motors", 32'({motor_l, motor_r}), 32'd0);
    check("rst_xcnt", 32'(crossing_cnt), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [2:0] follow_pats [6];

  initial begin
    follow_pats = '{3'b010, 3'b110, 3'b100, 3'b011, 3'b001, 3'b101};
    model_reset();
    #2;
    apply_reset();

    // Start from IDLE with centred line
    raw_v = 3'b010;
    step(2);
    tick(1'b1, 1'b0);
    check("start_state", 32'(state_o), 32'd1);
    check("start_motors", 32'({motor_l, motor_r}), 32'h5);

    // Short glitch is ignored, four-edge hold is accepted
    raw_v = 3'b110; step(3);
    raw_v = 3'b010; step(3);
    check("glitch_motors", 32'({motor_l, motor_r}), 32'h5);
    raw_v = 3'b110; step(4);
    check("steer_motors", 32'({motor_l, motor_r}), 32'h1);
    raw_v = 3'b010; step(5);

    // Random steering traffic
    for (int i = 0; i < 30; i++) begin
      raw_v = follow_pats[$urandom_range(0, 5)];
      step(int'($urandom_range(1, 6)));
    end
    raw_v = 3'b010; step(5);

    // Left turn at a crossing; late turn_sel change must not matter
    ts_v = 2'b01; raw_v = 3'b111; step(6);
    ts_v = 2'b10; raw_v = 3'b000;
    wait_state(3'd3, 10);
    check("turn_xcnt", 32'(crossing_cnt), 32'd1);
    step(TURN_CYC - 1);
    check("turn_hold", 32'(state_o), 32'd3);
    check("turn_motors", 32'({motor_l, motor_r}), 32'h9);
    step(1);
    check("seek_entry", 32'(state_o), 32'd4);
    raw_v = 3'b010;
    wait_state(3'd1, 10);

    // Line lost in FOLLOW
    raw_v = 3'b000;
    step(DEBOUNCE_CYC + LOST_CYC - 1);
    check("pre_lost", 32'(state_o), 32'd1);
    step(1);
    check("lost_state", 32'(state_o), 32'd5);
    check("lost_flag", 32'(lost), 32'd1);
    raw_v = 3'b010;
    tick(1'b1, 1'b0);
    check("relost_state", 32'(state_o), 32'd1);
    check("relost_flag", 32'(lost), 32'd0);
    step(5);

    // Halt crossing
    ts_v = 2'b11; raw_v = 3'b111; step(5);
    raw_v = 3'b010;
    wait_state(3'd0, 10);
    check("halt_xcnt", 32'(crossing_cnt), 32'd1);
    step(5);

    // start + stop together: stop wins
    tick(1'b1, 1'b0);
    step(2);
    tick(1'b1, 1'b1);
    check("stop_wins", 32'(state_o), 32'd0);

    // Random crossings
    tick(1'b1, 1'b0);
    step(5);
    for (int i = 0; i < 8; i++) begin
      ts_v = 2'($urandom_range(0, 2));
      raw_v = 3'b111; step(int'($urandom_range(5, 8)));
      raw_v = 3'b000;
      for (int k = int'($urandom_range(6, 30)); k > 0; k--) begin
        ts_v = 2'($urandom_range(0, 3));
        step(1);
      end
      raw_v = 3'b010;
      wait_state(3'd1, 100);
      step(5);
    end

    // Saturation of the crossing counter
    ts_v = 2'b00;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 256; i++) begin
      raw_v = 3'b111; step(5);
      raw_v = 3'b010; step(5);
      if (i == 254) check("xcnt_255", 32'(crossing_cnt), 32'd255);
    end
    check("xcnt_sat", 32'(crossing_cnt), 32'd255);

    // Asynchronous reset during a right turn
    ts_v = 2'b10; raw_v = 3'b111; step(5);
    raw_v = 3'b000; step(5);
    check("right_turn", 32'({motor_l, motor_r}), 32'h6);
    step(3);
    #2;
    apply_reset();
    step(3);
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_motors", 32'({motor_l, motor_r}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
